gshare_branch_predictor: RTL and testbench

Next-PC predictor for the 5-stage RV32I pipeline. Replaces the fixed PC+4 input of the IF-stage PC-source mux. Provides a combinational taken/target prediction for the PC currently in IF. Holds a direct-mapped BTB, a gshare PHT of 2-bit saturating counters, and a global history register (BHR). All three are trained from the EX stage once a branch or jump resolves.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/gshare_branch_predictor_if.sv | 30 +++
 rtl/bp_btb.sv | 31 +++
 rtl/gshare_branch_predictor.sv | 79 +++++++
 tb/tb_gshare_branch_predictor.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare next-PC predictor: sizes, counter
// encodings, BTB entry layout and saturating counter arithmetic.
package bp_pkg;

   localparam int IDX_BITS = 5;
   localparam int BHR_BITS = 5;
   localparam int TAG_BITS = 32 - IDX_BITS - 2;

   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   typedef struct packed {
      logic                valid;
      logic                uncond;
      logic [TAG_BITS-1:0] tag;
      logic [31:0]         target;
   } btb_entry;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == ST) ? ST : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == SNT) ? SNT : c - 2'd1;
   endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Fetch-side prediction and EX-side training signals of the branch predictor.
interface gshare_branch_predictor_if #(
   parameter int BHR_BITS = bp_pkg::BHR_BITS
);
   logic [31:0]         if_pc;
   logic                if_stall;
   logic                pred_taken;
   logic [31:0]         pred_next_pc;
   logic [BHR_BITS-1:0] pred_bhr;

   logic                upd_valid;
   logic [31:0]         upd_pc;
   logic                upd_is_branch;
   logic                upd_taken;
   logic [31:0]         upd_target;
   logic [BHR_BITS-1:0] upd_bhr;
   logic                upd_mispredict;

   modport master (
      output if_pc, if_stall, upd_valid, upd_pc, upd_is_branch, upd_taken,
             upd_target, upd_bhr, upd_mispredict,
      input  pred_taken, pred_next_pc, pred_bhr
   );

   modport slave (
      input  if_pc, if_stall, upd_valid, upd_pc, upd_is_branch, upd_taken,
             upd_target, upd_bhr, upd_mispredict,
      output pred_taken, pred_next_pc, pred_bhr
   );
endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: asynchronous read, synchronous write,
// synchronous clear of every entry on reset.
module bp_btb
   import bp_pkg::*;
#(
   parameter int IDX_BITS = bp_pkg::IDX_BITS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IDX_BITS-1:0] rd_idx,
   output btb_entry            rd_entry,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  btb_entry            wr_entry
);
   localparam int ENTRIES = 1 << IDX_BITS;

   btb_entry mem [ENTRIES];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_idx] <= wr_entry;
      end
   end

   // Same-cycle read of the entry being written sees the old contents.
   assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare next-PC predictor for the IF stage: BTB + 2-bit PHT + global history,
// trained from EX. BHR_BITS must be at least 2 and no larger than IDX_BITS.
module gshare_branch_predictor
   import bp_pkg::*;
#(
   parameter int IDX_BITS = bp_pkg::IDX_BITS,
   parameter int BHR_BITS = bp_pkg::BHR_BITS
) (
   input logic clk,
   input logic reset,
   gshare_branch_predictor_if.slave bp
);
   localparam int ENTRIES = 1 << IDX_BITS;

   logic [BHR_BITS-1:0] bhr;
   logic [1:0]          pht [ENTRIES];

   logic [IDX_BITS-1:0] rd_idx, pht_rd_idx, upd_idx, pht_upd_idx;
   btb_entry            rd_entry, wr_entry;
   logic                hit, cond_hit, taken, wr_en;
   logic [3:0]          unused_pc_lsbs;

   assign rd_idx      = bp.if_pc[IDX_BITS+1:2];
   assign upd_idx     = bp.upd_pc[IDX_BITS+1:2];
   assign pht_rd_idx  = rd_idx ^ IDX_BITS'(bhr);
   assign pht_upd_idx = upd_idx ^ IDX_BITS'(bp.upd_bhr);
   assign unused_pc_lsbs = {bp.if_pc[1:0], bp.upd_pc[1:0]};

   bp_btb #(.IDX_BITS(IDX_BITS)) u_btb (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (rd_idx),
      .rd_entry (rd_entry),
      .wr_en    (wr_en),
      .wr_idx   (upd_idx),
      .wr_entry (wr_entry)
   );

   assign hit      = rd_entry.valid && (rd_entry.tag == bp.if_pc[31:IDX_BITS+2]);
   assign cond_hit = hit && !rd_entry.uncond;
   assign taken    = hit && (rd_entry.uncond || pht[pht_rd_idx][1]);

   assign bp.pred_taken   = taken;
   assign bp.pred_next_pc = taken ? rd_entry.target : bp.if_pc + 32'd4;
   assign bp.pred_bhr     = bhr;

   // Only taken outcomes allocate, so not-taken branches never evict a jump.
   assign wr_en = bp.upd_valid && bp.upd_taken;
   always_comb begin
      wr_entry        = '0;
      wr_entry.valid  = 1'b1;
      wr_entry.uncond = !bp.upd_is_branch;
      wr_entry.tag    = bp.upd_pc[31:IDX_BITS+2];
      wr_entry.target = bp.upd_target;
   end

   // A mispredict restores the history snapshot that travelled with the
   // instruction, so the repair wins over the speculative shift.
   always_ff @(posedge clk) begin
      if (reset)
         bhr <= '0;
      else if (bp.upd_valid && bp.upd_mispredict && bp.upd_is_branch)
         bhr <= {bp.upd_bhr[BHR_BITS-2:0], bp.upd_taken};
      else if (bp.upd_valid && bp.upd_mispredict)
         bhr <= bp.upd_bhr;
      else if (!bp.if_stall && cond_hit)
         bhr <= {bhr[BHR_BITS-2:0], taken};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) pht[i] <= WNT;
      end else if (bp.upd_valid && bp.upd_is_branch) begin
         pht[pht_upd_idx] <= bp.upd_taken ? sat_inc(pht[pht_upd_idx])
                                          : sat_dec(pht[pht_upd_idx]);
      end
   end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for the gshare predictor: expected predictions are queued
// when a fetch PC is driven and compared once the combinational outputs settle.
module tb_gshare_branch_predictor;
   localparam int BHR_BITS = 5;

   typedef struct {
      string               name;
      logic                taken;
      logic [31:0]         next_pc;
      logic [BHR_BITS-1:0] bhr;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;
   exp_t exp_q [$];

   gshare_branch_predictor_if #(.BHR_BITS(BHR_BITS)) bp_if ();

   gshare_branch_predictor dut (
      .clk   (clk),
      .reset (reset),
      .bp    (bp_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change 2 time units after the active edge, well clear of it.
   task automatic step();
      @(posedge clk);
      #2;
      bp_if.upd_valid = 1'b0;
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic is_br, input logic tk,
                          input logic [31:0] tgt, input logic [BHR_BITS-1:0] hist,
                          input logic misp);
      bp_if.upd_valid      = 1'b1;
      bp_if.upd_pc         = pc;
      bp_if.upd_is_branch  = is_br;
      bp_if.upd_taken      = tk;
      bp_if.upd_target     = tgt;
      bp_if.upd_bhr        = hist;
      bp_if.upd_mispredict = misp;
   endtask

   task automatic upd(input logic [31:0] pc, input logic is_br, input logic tk,
                      input logic [31:0] tgt, input logic [BHR_BITS-1:0] hist,
                      input logic misp);
      set_upd(pc, is_br, tk, tgt, hist, misp);
      step();
   endtask

   task automatic query(input string name, input logic [31:0] pc, input logic e_tk,
                        input logic [31:0] e_next, input logic [BHR_BITS-1:0] e_bhr);
      exp_t e;
      bp_if.if_pc = pc;
      exp_q.push_back('{name, e_tk, e_next, e_bhr});
      #1;
      e = exp_q.pop_front();
      chk({e.name, ".taken"}, 32'(bp_if.pred_taken), 32'(e.taken));
      chk({e.name, ".next"},  bp_if.pred_next_pc,    e.next_pc);
      chk({e.name, ".bhr"},   32'(bp_if.pred_bhr),   32'(e.bhr));
   endtask

   initial begin
      reset = 1'b1;
      bp_if.if_pc = 32'h0;
      bp_if.if_stall = 1'b1;
      set_upd(32'h0, 1'b0, 1'b0, 32'h0, '0, 1'b0);
      step();
      step();
      reset = 1'b0;

      query("rst", 32'h10, 1'b0, 32'h14, 5'd0);

      // jal 0x20 -> 0x80; the write is not visible during its own cycle
      set_upd(32'h20, 1'b0, 1'b1, 32'h80, 5'd0, 1'b0);
      query("jal_coll", 32'h20, 1'b0, 32'h24, 5'd0);
      step();
      query("jal_hit", 32'h20, 1'b1, 32'h80, 5'd0);
      query("tag_miss", 32'hA0, 1'b0, 32'hA4, 5'd0);

      // conditional branch 0x40 -> 0x10, counter starts weakly not-taken
      upd(32'h40, 1'b1, 1'b1, 32'h10, 5'd0, 1'b0);
      query("br_t1", 32'h40, 1'b1, 32'h10, 5'd0);
      upd(32'h40, 1'b1, 1'b0, 32'h10, 5'd0, 1'b0);
      query("br_nt1", 32'h40, 1'b0, 32'h44, 5'd0);
      upd(32'h40, 1'b1, 1'b0, 32'h10, 5'd0, 1'b0);
      query("br_nt2", 32'h40, 1'b0, 32'h44, 5'd0);

      // saturation: 0 -> 5 taken -> 3, then 3 -> 2 (taken) -> 1 (not taken)
      for (int i = 0; i < 5; i++) upd(32'h40, 1'b1, 1'b1, 32'h10, 5'd0, 1'b0);
      upd(32'h40, 1'b1, 1'b0, 32'h10, 5'd0, 1'b0);
      query("sat_hi", 32'h40, 1'b1, 32'h10, 5'd0);
      upd(32'h40, 1'b1, 1'b0, 32'h10, 5'd0, 1'b0);
      query("sat_dn", 32'h40, 1'b0, 32'h44, 5'd0);

      // mispredict repair beats the speculative shift on the same edge
      upd(32'h40, 1'b1, 1'b1, 32'h10, 5'd0, 1'b0);
      bp_if.if_stall = 1'b0;
      set_upd(32'h100, 1'b1, 1'b0, 32'h0, 5'b00100, 1'b1);
      query("prio_pre", 32'h40, 1'b1, 32'h10, 5'd0);
      step();
      bp_if.if_stall = 1'b1;
      query("prio_bhr", 32'h40, 1'b0, 32'h44, 5'b01000);

      // speculative shift of a not-taken prediction
      bp_if.if_stall = 1'b0;
      step();
      bp_if.if_stall = 1'b1;
      query("spec_nt", 32'h40, 1'b0, 32'h44, 5'b10000);

      // jump mispredict restores the snapshot unshifted
      upd(32'h20, 1'b0, 1'b1, 32'h80, 5'b00011, 1'b1);
      query("jmp_rest", 32'h20, 1'b1, 32'h80, 5'b00011);

      // stall suppresses the shift, release lets it through
      query("stall_pre", 32'h40, 1'b0, 32'h44, 5'b00011);
      step();
      query("stall_hold", 32'h40, 1'b0, 32'h44, 5'b00011);
      bp_if.if_stall = 1'b0;
      step();
      bp_if.if_stall = 1'b1;
      query("stall_rel", 32'h40, 1'b0, 32'h44, 5'b00110);

      // reset overrides a concurrent update
      reset = 1'b1;
      set_upd(32'h60, 1'b0, 1'b1, 32'hC0, 5'b00111, 1'b1);
      step();
      reset = 1'b0;
      query("rst_btb", 32'h20, 1'b0, 32'h24, 5'd0);
      query("rst_upd", 32'h60, 1'b0, 32'h64, 5'd0);

      // PHT back to weakly not-taken: taken then not-taken leaves it not-taken
      upd(32'h40, 1'b1, 1'b1, 32'h10, 5'd0, 1'b0);
      upd(32'h40, 1'b1, 1'b0, 32'h10, 5'd0, 1'b0);
      query("rst_pht", 32'h40, 1'b0, 32'h44, 5'd0);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
